// File: rtl/mv_pkg.sv
// Shared definitions for the motion-vector memory path. The serializer and the
// row loader both import this package so address packing ({row, col}) and
// byte order (col 0 in the LSB byte) stay in agreement.
package mv_pkg;

    localparam int unsigned MV_ROWS   = 6;
    localparam int unsigned MV_COLS   = 8;
    localparam int unsigned MV_W      = 8;
    localparam int unsigned MV_ROW_W  = 64;
    localparam int unsigned MV_ADDR_W = 6;
    localparam int unsigned MV_COL_W  = 3;
    localparam int unsigned MV_RSEL_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StHold
    } loader_state_e;

endpackage

// File: rtl/mv_rd_tag_pipe.sv
// Read tag pipeline: a DEPTH-deep shift register of {valid, col} that lines up
// each issued read with its returning data from the MV memory.
// Ports:
//   clk, rst_n - clock, asynchronous active-low clear
//   vld_i      - a read is issued this cycle
//   col_i      - column of the issued read
//   vld_o      - read data for col_o is on the memory data bus this cycle
//   col_o      - column the current read data belongs to
module mv_rd_tag_pipe
    import mv_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld_i,
    input  logic [MV_COL_W-1:0] col_i,
    output logic                vld_o,
    output logic [MV_COL_W-1:0] col_o
);

    logic [DEPTH-1:0]               vld_q;
    logic [DEPTH-1:0][MV_COL_W-1:0] col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            col_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            col_q[0] <= col_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
                col_q[i] <= col_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign col_o = col_q[DEPTH-1];

endmodule

// File: rtl/mv_row_loader.sv
// MV row loader: fetches one 8-byte row from the 6x8 MV memory one byte per
// cycle, reassembles the 64-bit word and presents it with valid/ready.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_i/row_i - row fetch request (accepted in IDLE only, rows 0..5)
//   busy_o      - fetch in progress (state not IDLE)
//   err_o       - one-cycle pulse, registered, on a rejected request
//   mv_ren_o, mv_addr_o, mv_rdata_i - MV memory read port, latency RD_LAT
//   valid_o, ready_i, mv_o          - assembled row output, col 0 in LSB byte
module mv_row_loader
    import mv_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_i,
    input  logic [MV_RSEL_W-1:0] row_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 mv_ren_o,
    output logic [MV_ADDR_W-1:0] mv_addr_o,
    input  logic [MV_W-1:0]      mv_rdata_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [MV_ROW_W-1:0]  mv_o
);

    loader_state_e state_q, state_d;
    logic [MV_RSEL_W-1:0] row_q, row_d;
    logic [MV_COL_W-1:0]  col_q, col_d;
    logic                 err_q, err_d;
    logic [MV_COLS-1:0][MV_W-1:0] asm_q;

    logic                accept;
    logic                tag_vld;
    logic [MV_COL_W-1:0] tag_col;
    logic                last_cap;

    assign accept   = (state_q == StIdle) && req_i && (row_i < 3'(MV_ROWS));
    assign last_cap = tag_vld && (tag_col == 3'(MV_COLS - 1));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        mv_ren_o  = 1'b0;
        mv_addr_o = '0;
        // Any request not accepted (bad row, or fetch already running) is flagged.
        err_d     = req_i && !accept;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRead;
                    row_d   = row_i;
                    col_d   = '0;
                end
            end
            StRead: begin
                mv_ren_o  = 1'b1;
                mv_addr_o = {row_q, col_q};
                col_d     = col_q + 3'd1;  // wraps 7->0 only on the exit to DRAIN
                if (col_q == 3'(MV_COLS - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_cap) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    mv_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (mv_ren_o),
        .col_i (col_q),
        .vld_o (tag_vld),
        .col_o (tag_col)
    );

    // Cleared on accept so lanes never carry bytes from a previous row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
        end else if (accept) begin
            asm_q <= '0;
        end else if (tag_vld) begin
            asm_q[tag_col] <= mv_rdata_i;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign err_o   = err_q;
    assign valid_o = (state_q == StHold);
    assign mv_o    = asm_q;

endmodule

// File: tb/tb_mv_row_loader.sv
// Bench for mv_row_loader: one instance with RD_LAT=1, one with RD_LAT=3, each
// attached to a behavioural MV memory. Expected addresses and rows are queued
// when a request is driven and popped when the DUT issues/presents them.
module tb_mv_row_loader;

    logic clk;
    logic rst_n;

    logic        req1, ready1, busy1, err1, ren1, valid1;
    logic [2:0]  row1;
    logic [5:0]  addr1;
    logic [7:0]  rdata1;
    logic [63:0] mv1;

    logic        req3, ready3, busy3, err3, ren3, valid3;
    logic [2:0]  row3;
    logic [5:0]  addr3;
    logic [7:0]  rdata3;
    logic [63:0] mv3;

    logic [7:0]  mem [64];
    logic [7:0]  p1;
    logic [7:0]  p3 [3];

    logic [63:0] row_sb [$];
    logic [5:0]  addr_sb [$];

    int n_checks;
    int n_fail;

    mv_row_loader #(.RD_LAT(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req1),
        .row_i      (row1),
        .busy_o     (busy1),
        .err_o      (err1),
        .mv_ren_o   (ren1),
        .mv_addr_o  (addr1),
        .mv_rdata_i (rdata1),
        .valid_o    (valid1),
        .ready_i    (ready1),
        .mv_o       (mv1)
    );

    mv_row_loader #(.RD_LAT(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req3),
        .row_i      (row3),
        .busy_o     (busy3),
        .err_o      (err3),
        .mv_ren_o   (ren3),
        .mv_addr_o  (addr3),
        .mv_rdata_i (rdata3),
        .valid_o    (valid3),
        .ready_i    (ready3),
        .mv_o       (mv3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: data appears 1 resp. 3 cycles after the address.
    always @(posedge clk) begin
        p1    <= mem[addr1];
        p3[0] <= mem[addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata1 = p1;
    assign rdata3 = p3[2];

    task automatic drive_req(input bit sel, input logic r, input logic [2:0] rw);
        if (sel) begin req3 = r; row3 = rw; end
        else     begin req1 = r; row1 = rw; end
    endtask

    task automatic drive_ready(input bit sel, input logic r);
        if (sel) ready3 = r;
        else     ready1 = r;
    endtask

    task automatic obs(input bit sel, output logic busy, output logic err, output logic ren,
                       output logic [5:0] addr, output logic valid, output logic [63:0] mv);
        busy  = sel ? busy3  : busy1;
        err   = sel ? err3   : err1;
        ren   = sel ? ren3   : ren1;
        addr  = sel ? addr3  : addr1;
        valid = sel ? valid3 : valid1;
        mv    = sel ? mv3    : mv1;
    endtask

    // Starts in an IDLE cycle at a negedge; returns at the negedge of the
    // cycle after the handshake.
    task automatic fetch(input bit sel, input int row, input int hold, input int inject);
        logic        busy, err, ren, valid;
        logic [5:0]  addr, exp_a;
        logic [63:0] mv, exp_row, first;
        int          cyc, lat;
        bit          done;
        lat = sel ? 3 : 1;
        exp_row = '0;
        for (int k = 0; k < 8; k++) begin
            exp_row[8*k +: 8] = mem[row*8 + k];
            addr_sb.push_back(6'(row*8 + k));
        end
        row_sb.push_back(exp_row);
        drive_req(sel, 1'b1, 3'(row));
        @(negedge clk);
        drive_req(sel, 1'b0, 3'd0);
        cyc  = 1;
        done = 0;
        obs(sel, busy, err, ren, addr, valid, mv);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_cycle1 lat%0d: got %b expected 1", lat, busy);
        end
        while (!done && cyc < 40) begin
            obs(sel, busy, err, ren, addr, valid, mv);
            if (ren === 1'b1) begin
                n_checks++;
                if (addr_sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_read lat%0d: got addr %h expected no read", lat, addr);
                end else begin
                    exp_a = addr_sb.pop_front();
                    if (addr !== exp_a) begin
                        n_fail++;
                        $display("FAIL rd_addr lat%0d: got %h expected %h", lat, addr, exp_a);
                    end
                    n_checks++;
                    if (cyc !== int'(exp_a[2:0]) + 1) begin
                        n_fail++;
                        $display("FAIL rd_cycle lat%0d: got %0d expected %0d", lat, cyc,
                                 int'(exp_a[2:0]) + 1);
                    end
                end
            end
            if (cyc == inject + 1) begin
                n_checks++;
                if (err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err_mid_read lat%0d: got %b expected 1", lat, err);
                end
                drive_req(sel, 1'b0, 3'd0);
            end
            if (cyc == inject) drive_req(sel, 1'b1, 3'd1);
            if (valid === 1'b1) begin
                done = 1;
                n_checks++;
                if (cyc !== 9 + lat) begin
                    n_fail++;
                    $display("FAIL valid_cycle lat%0d: got %0d expected %0d", lat, cyc, 9 + lat);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout lat%0d: got no valid expected valid by cycle %0d",
                     lat, 9 + lat);
            return;
        end
        n_checks++;
        if (addr_sb.size() != 0) begin
            n_fail++;
            $display("FAIL read_count lat%0d: got %0d missing expected 0", lat, addr_sb.size());
            addr_sb.delete();
        end
        first = mv;
        for (int h = 0; h <= hold; h++) begin
            obs(sel, busy, err, ren, addr, valid, mv);
            if (h > 0) begin
                n_checks++;
                if (valid !== 1'b1 || mv !== first) begin
                    n_fail++;
                    $display("FAIL hold_stable lat%0d: got valid %b mv %h expected 1 %h",
                             lat, valid, mv, first);
                end
            end
            if (h == hold) begin
                drive_ready(sel, 1'b1);
                n_checks++;
                if (row_sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL row_unexpected lat%0d: got %h expected none", lat, mv);
                end else begin
                    exp_row = row_sb.pop_front();
                    if (mv !== exp_row) begin
                        n_fail++;
                        $display("FAIL row_data lat%0d: got %h expected %h", lat, mv, exp_row);
                    end
                end
            end
            @(negedge clk);
        end
        drive_ready(sel, 1'b0);
        obs(sel, busy, err, ren, addr, valid, mv);
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_handshake lat%0d: got busy %b valid %b expected 0 0",
                     lat, busy, valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({busy1, err1, ren1, valid1} !== 4'b0000 || addr1 !== 6'd0 || mv1 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy %b err %b ren %b valid %b addr %h mv %h expected all 0",
                     busy1, err1, ren1, valid1, addr1, mv1);
        end
        n_checks++;
        if ({busy3, err3, ren3, valid3} !== 4'b0000 || mv3 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state_lat3: got busy %b err %b ren %b valid %b mv %h expected all 0",
                     busy3, err3, ren3, valid3, mv3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reject();
        logic [2:0] bad;
        for (int i = 0; i < 2; i++) begin
            bad = 3'(6 + i);
            drive_req(1'b0, 1'b1, bad);
            @(negedge clk);
            drive_req(1'b0, 1'b0, 3'd0);
            n_checks++;
            if (err1 !== 1'b1 || ren1 !== 1'b0 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_row%0d: got err %b ren %b busy %b expected 1 0 0",
                         bad, err1, ren1, busy1);
            end
            @(negedge clk);
            n_checks++;
            if (err1 !== 1'b0 || ren1 !== 1'b0 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_after_row%0d: got err %b ren %b busy %b expected 0 0 0",
                         bad, err1, ren1, busy1);
            end
        end
    endtask

    task automatic test_back_to_back();
        fetch(1'b0, 5, 0, -10);
        fetch(1'b0, 0, 1, -10);
    endtask

    task automatic test_rd_lat3();
        fetch(1'b1, 2, 0, -10);
        fetch(1'b1, 4, 2, 3);
    endtask

    task automatic test_reset_abort();
        drive_req(1'b0, 1'b1, 3'd3);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 3'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy1, err1, ren1, valid1} !== 4'b0000 || addr1 !== 6'd0 || mv1 !== 64'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy %b err %b ren %b valid %b addr %h mv %h expected all 0",
                     busy1, err1, ren1, valid1, addr1, mv1);
        end
        addr_sb.delete();
        row_sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(1'b0, 1, 0, -10);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        req1 = 1'b0; row1 = 3'd0; ready1 = 1'b0;
        req3 = 1'b0; row3 = 3'd0; ready3 = 1'b0;
        for (int a = 0; a < 64; a++) mem[a] = 8'((a * 29 + 7) % 256);
        for (int k = 0; k < 8; k++) mem[16 + k] = 8'(17 * (k + 1));  // row 2 = 0x8877..2211
        test_reset();
        fetch(1'b0, 2, 5, -10);
        test_reject();
        test_back_to_back();
        test_rd_lat3();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
